spi_flash_bridge: RTL and testbench
===================================

SPI_FLASH_BRIDGE -- requirements
Module: spi_flash_bridge

Interface
REQ-001 Parameter ADDR_BYTES, default 3, SHALL set the flash address width in bytes (1..4); AW = 8*ADDR_BYTES.
REQ-002 Parameter MAX_BURST, default 16, SHALL set the maximum bytes per READ burst (1..255).
REQ-003 Parameter FIFO_DEPTH, default 16, SHALL set the read-data FIFO entries (2..127).
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 recv_data  in  8  SHALL be the byte from spi_slave, valid when recv_ready=1.
REQ-007 recv_ready  in  1  SHALL be a one-cycle pulse per received SPI byte.
REQ-008 send_data  out  8  SHALL be the registered reply byte shifted out during the next SPI byte.
REQ-009 flash_addr  out  AW  SHALL be the qspi_flash read address, stable while flash_do_read=1.
REQ-010 flash_do_read  out  1  SHALL be the read request level to qspi_flash.
REQ-011 flash_setup_done  in  1  SHALL indicate qspi_flash is initialised.
REQ-012 flash_data_ready  in  1  SHALL be a one-cycle pulse with flash_data valid.
REQ-013 flash_data  in  8  SHALL be the byte returned by qspi_flash.
REQ-014 busy  out  1  SHALL be high while a burst is active or draining.
REQ-015 led  out  1  SHALL be the debug LED register.

Function
REQ-016 Command FSM states SHALL be CMD_IDLE, CMD_ADDR, CMD_LEN; it acts only on cycles with recv_ready=1.
REQ-017 In CMD_IDLE the decoder SHALL map bytes: 0x00->send 0x00; 0x02->toggle led, send 0xAB; 0xCC->send 0xCC; 0x03 STATUS->send {busy, fifo_count[6:0]}; 0x10+i (i<ADDR_BYTES)->send flash_addr byte i; any other->send 0xEE.
REQ-018 0x01 READ SHALL, when busy=0, go to CMD_ADDR, load addr counter ADDR_BYTES, send ADDR_BYTES; when busy=1 send 0xEB and stay CMD_IDLE.
REQ-019 CMD_ADDR SHALL shift recv_data into addr register MSB first, send remaining count minus one, go to CMD_LEN after the ADDR_BYTES-th byte.
REQ-020 CMD_LEN SHALL latch burst length = recv_data, with 0 or >MAX_BURST clamped to MAX_BURST, send the clamped length, start the burst engine, return to CMD_IDLE.
REQ-021 0x04 POP SHALL send FIFO head and pop when non-empty; when empty send 0xFE, no pop.
REQ-022 0x05 ABORT SHALL send 0xAA, flush the FIFO same cycle, and stop further flash requests.
REQ-023 Burst engine states SHALL be B_IDLE, B_ISSUE, B_WAIT, B_DRAIN.
REQ-024 B_ISSUE SHALL assert flash_do_read only when flash_setup_done=1 and fifo_count + 0 < FIFO_DEPTH, then enter B_WAIT.
REQ-025 flash_do_read SHALL stay high until the cycle of flash_data_ready, deasserting the following cycle.
REQ-026 On flash_data_ready in B_WAIT the engine SHALL push flash_data, increment flash_addr modulo 2^AW, decrement remaining; remaining=0 -> B_IDLE, else B_ISSUE.
REQ-027 ABORT during B_WAIT SHALL move to B_DRAIN: outstanding read completes, data discarded, then B_IDLE; never drop flash_do_read early.
REQ-028 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-029 Push when full SHALL never occur (REQ-024 guarantees it); pop when empty SHALL be a no-op.
REQ-030 send_data SHALL change only on recv_ready cycles.
REQ-031 busy SHALL be 1 in B_ISSUE, B_WAIT, B_DRAIN; 0 in B_IDLE.

Reset
REQ-032 rst=1 SHALL set: send_data=0x00, flash_addr=0, flash_do_read=0, busy=0, led=1, FIFO empty, both FSMs to idle states, all counters 0.
REQ-033 rst during B_WAIT SHALL abandon the read; a late flash_data_ready SHALL be ignored in B_IDLE.

Verification
- rst, then recv 0x02 twice -> send_data 0xAB each, led 1->0->1.
- Defaults: recv 0x01,0x12,0x34,0x56,0x04 -> replies 3,2,1,0,4; flash_addr 0x123456..0x123459 over 4 reads; 4 POPs return flash bytes in order; 5th POP -> 0xFE.
- Addr 0xFFFFFF, length 2 -> reads at 0xFFFFFF then 0x000000.
- Length 0x00 and 0xC8 -> both clamp to 16; FIFO_DEPTH=4 with no POPs -> do_read stalls at count 4, resumes after a POP; STATUS shows 0x84.
- ABORT while do_read=1 -> reply 0xAA, FIFO empty, do_read held until data_ready, byte discarded, busy falls next cycle; READ while busy -> 0xEB.
- rst mid-burst -> all outputs per REQ-032 next cycle; later data_ready pulse leaves FIFO empty.

Source files
------------

// File: rtl/spi_flash_bridge.sv
// SPI command decoder that bridges a byte-oriented spi_slave to a qspi_flash reader.
// READ bursts fetch flash bytes one at a time into a small FIFO that the host drains with POP.
module spi_flash_bridge #(
  parameter int ADDR_BYTES = 3,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 16,
  localparam int AW = 8 * ADDR_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    recv_data,
  input  logic          recv_ready,
  output logic [7:0]    send_data,
  output logic [AW-1:0] flash_addr,
  output logic          flash_do_read,
  input  logic          flash_setup_done,
  input  logic          flash_data_ready,
  input  logic [7:0]    flash_data,
  output logic          busy,
  output logic          led
);
  localparam int            PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [6:0]    DEPTH_C  = 7'(FIFO_DEPTH);
  localparam logic [7:0]    MAX_C    = 8'(MAX_BURST);
  localparam logic [2:0]    ABYTES_C = 3'(ADDR_BYTES);

  typedef enum logic [1:0] {CMD_IDLE, CMD_ADDR, CMD_LEN} cmd_state_e;
  typedef enum logic [1:0] {B_IDLE, B_ISSUE, B_WAIT, B_DRAIN} burst_state_e;

  cmd_state_e   cmd_q, cmd_d;
  burst_state_e bst_q, bst_d;
  logic [7:0]    send_q, send_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          do_read_q, do_read_d;
  logic          led_q, led_d;
  logic [2:0]    acnt_q, acnt_d;
  logic [7:0]    remain_q, remain_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [6:0]    count_q, count_d;
  logic          push, pop, abort;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    fifo_head;
  logic [AW+7:0] addr_shift;
  logic [AW-1:0] addr_sel;
  logic [7:0]    len_clamped;

  assign fifo_head   = mem[rd_ptr_q];
  assign addr_shift  = {addr_q, recv_data};
  assign addr_sel    = addr_q >> {recv_data[1:0], 3'b000};
  assign len_clamped = (recv_data == 8'h00 || recv_data > MAX_C) ? MAX_C : recv_data;

  assign busy          = (bst_q != B_IDLE);
  assign send_data     = send_q;
  assign flash_addr    = addr_q;
  assign flash_do_read = do_read_q;
  assign led           = led_q;

  // NOTE: every next-state value gets its hold default first so no path infers a latch.
  always_comb begin
    cmd_d    = cmd_q;
    bst_d    = bst_q;
    send_d   = send_q;
    addr_d   = addr_q;
    led_d    = led_q;
    acnt_d   = acnt_q;
    remain_d = remain_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push     = 1'b0;
    pop      = 1'b0;
    abort    = 1'b0;

    if (recv_ready) begin
      case (cmd_q)
        CMD_IDLE: begin
          case (recv_data)
            8'h00: send_d = 8'h00;
            8'h01: begin
              if (busy) begin
                send_d = 8'hEB;
              end else begin
                cmd_d  = CMD_ADDR;
                acnt_d = ABYTES_C;
                send_d = {5'd0, ABYTES_C};
              end
            end
            8'h02: begin
              led_d  = ~led_q;
              send_d = 8'hAB;
            end
            8'h03: send_d = {busy, count_q};
            8'h04: begin
              if (count_q != 7'd0) begin
                send_d = fifo_head;
                pop    = 1'b1;
              end else begin
                send_d = 8'hFE;
              end
            end
            8'h05: begin
              send_d = 8'hAA;
              abort  = 1'b1;
            end
            8'hCC: send_d = 8'hCC;
            default: begin
              if (recv_data[7:2] == 6'b000100 && {1'b0, recv_data[1:0]} < ABYTES_C)
                send_d = addr_sel[7:0];
              else
                send_d = 8'hEE;
            end
          endcase
        end
        CMD_ADDR: begin
          addr_d = addr_shift[AW-1:0];
          send_d = {5'd0, acnt_q - 3'd1};
          acnt_d = acnt_q - 3'd1;
          if (acnt_q == 3'd1) cmd_d = CMD_LEN;
        end
        CMD_LEN: begin
          remain_d = len_clamped;
          send_d   = len_clamped;
          bst_d    = B_ISSUE;
          cmd_d    = CMD_IDLE;
        end
        default: cmd_d = CMD_IDLE;
      endcase
    end

    // A read already on the wire must complete, so ABORT in B_WAIT drains instead of dropping it.
    case (bst_q)
      B_ISSUE: begin
        if (abort)
          bst_d = B_IDLE;
        else if (flash_setup_done && count_q < DEPTH_C)
          bst_d = B_WAIT;
      end
      B_WAIT: begin
        if (flash_data_ready) begin
          if (abort) begin
            bst_d = B_IDLE;
          end else begin
            push     = 1'b1;
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 8'd1;
            bst_d    = (remain_q == 8'd1) ? B_IDLE : B_ISSUE;
          end
        end else if (abort) begin
          bst_d = B_DRAIN;
        end
      end
      B_DRAIN: if (flash_data_ready) bst_d = B_IDLE;
      default: ;
    endcase

    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 7'd0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 7'd1;
      else if (pop && !push) count_d = count_q - 7'd1;
    end
  end

  assign do_read_d = (bst_d == B_WAIT) || (bst_d == B_DRAIN);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= CMD_IDLE;
      bst_q     <= B_IDLE;
      send_q    <= 8'h00;
      addr_q    <= '0;
      do_read_q <= 1'b0;
      led_q     <= 1'b1;
      acnt_q    <= 3'd0;
      remain_q  <= 8'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 7'd0;
    end else begin
      cmd_q     <= cmd_d;
      bst_q     <= bst_d;
      send_q    <= send_d;
      addr_q    <= addr_d;
      do_read_q <= do_read_d;
      led_q     <= led_d;
      acnt_q    <= acnt_d;
      remain_q  <= remain_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: the data array is not reset; emptiness is tracked by count_q, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= flash_data;
  end

endmodule

// File: tb/tb_spi_flash_bridge.sv
// Bench for spi_flash_bridge: command table, then read/abort/reset sequences against a flash model.
// FIFO_DEPTH is 4 so the full-FIFO stall is reachable with a clamped 16-byte burst.
module tb_spi_flash_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  recv_data;
  logic        recv_ready;
  logic [7:0]  send_data;
  logic [23:0] flash_addr;
  logic        flash_do_read;
  logic        flash_setup_done;
  logic        flash_data_ready;
  logic [7:0]  flash_data;
  logic        busy;
  logic        led;

  spi_flash_bridge #(.ADDR_BYTES(3), .MAX_BURST(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .recv_data(recv_data), .recv_ready(recv_ready), .send_data(send_data),
    .flash_addr(flash_addr), .flash_do_read(flash_do_read),
    .flash_setup_done(flash_setup_done), .flash_data_ready(flash_data_ready),
    .flash_data(flash_data), .busy(busy), .led(led)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  exp_q[$];
  logic [23:0] exp_addr_q[$];
  bit model_en  = 1'b1;
  bit pulse_req = 1'b0;

  function automatic logic [7:0] mb(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One SPI byte: drive on a falling edge, sample the reply on the next falling edge.
  task automatic xfer(input logic [7:0] b, input logic [7:0] exp, input string name);
    recv_data  = b;
    recv_ready = 1'b1;
    @(negedge clk);
    recv_ready = 1'b0;
    check(name, {24'd0, send_data}, {24'd0, exp});
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFE;
    xfer(8'h04, e, name);
  endtask

  task automatic wait_rd(input logic lvl, input int max, input string name);
    int n = 0;
    while (flash_do_read !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, flash_do_read}, {31'd0, lvl});
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic start_read(input logic [23:0] a, input logic [7:0] len, input logic [7:0] eff);
    for (int i = 0; i < eff; i++) begin
      exp_q.push_back(mb(a + 24'(i)));
      exp_addr_q.push_back(a + 24'(i));
    end
    xfer(8'h01, 8'h03, "read_cmd");
    xfer(a[23:16], 8'h02, "addr_b2");
    xfer(a[15:8], 8'h01, "addr_b1");
    xfer(a[7:0], 8'h00, "addr_b0");
    xfer(len, eff, "len_reply");
  endtask

  // Flash model: answers a held read after 3 cycles, checks the address it was asked for.
  initial begin
    int cnt = 0;
    flash_data_ready = 1'b0;
    flash_data       = 8'h00;
    forever begin
      @(negedge clk);
      flash_data_ready = 1'b0;
      if (pulse_req) begin
        flash_data_ready = 1'b1;
        flash_data       = 8'h99;
        pulse_req        = 1'b0;
      end else if (model_en && flash_do_read === 1'b1) begin
        cnt++;
        if (cnt >= 3) begin
          cnt = 0;
          flash_data_ready = 1'b1;
          flash_data       = mb(flash_addr);
          if (exp_addr_q.size() > 0) check("read_addr", {8'd0, flash_addr}, {8'd0, exp_addr_q.pop_front()});
        end
      end else begin
        cnt = 0;
      end
    end
  end

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] reply;
    logic       led;
  } vec_t;
  vec_t vecs[12];

  initial begin
    vecs[0]  = '{8'h02, 8'hAB, 1'b0};
    vecs[1]  = '{8'h02, 8'hAB, 1'b1};
    vecs[2]  = '{8'hCC, 8'hCC, 1'b1};
    vecs[3]  = '{8'h00, 8'h00, 1'b1};
    vecs[4]  = '{8'h03, 8'h00, 1'b1};
    vecs[5]  = '{8'h10, 8'h00, 1'b1};
    vecs[6]  = '{8'h12, 8'h00, 1'b1};
    vecs[7]  = '{8'h13, 8'hEE, 1'b1};
    vecs[8]  = '{8'h7F, 8'hEE, 1'b1};
    vecs[9]  = '{8'h04, 8'hFE, 1'b1};
    vecs[10] = '{8'h05, 8'hAA, 1'b1};
    vecs[11] = '{8'hFF, 8'hEE, 1'b1};

    rst              = 1'b1;
    recv_data        = 8'h00;
    recv_ready       = 1'b0;
    flash_setup_done = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_send", {24'd0, send_data}, 32'h00);
    check("rst_addr", {8'd0, flash_addr}, 32'h0);
    check("rst_do_read", {31'd0, flash_do_read}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_led", {31'd0, led}, 32'd1);

    foreach (vecs[i]) begin
      xfer(vecs[i].cmd, vecs[i].reply, $sformatf("vec%0d_reply", i));
      check($sformatf("vec%0d_led", i), {31'd0, led}, {31'd0, vecs[i].led});
    end

    // Default read of 4 bytes, held off by flash_setup_done=0 at first.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mb(24'h123456 + 24'(i)));
      exp_addr_q.push_back(24'h123456 + 24'(i));
    end
    xfer(8'h01, 8'h03, "read_cmd");
    xfer(8'h12, 8'h02, "addr_b2");
    xfer(8'h34, 8'h01, "addr_b1");
    xfer(8'h56, 8'h00, "addr_b0");
    flash_setup_done = 1'b0;
    xfer(8'h04, 8'h04, "len_reply");
    repeat (5) @(negedge clk);
    check("setup_stall_rd", {31'd0, flash_do_read}, 32'd0);
    check("setup_stall_busy", {31'd0, busy}, 32'd1);
    flash_setup_done = 1'b1;
    wait_idle(200, "burst1_done");
    xfer(8'h03, 8'h04, "status_full_idle");
    xfer(8'h10, 8'h5A, "addr_byte0");
    xfer(8'h12, 8'h12, "addr_byte2");
    for (int i = 0; i < 4; i++) pop_check($sformatf("pop1_%0d", i));
    xfer(8'h04, 8'hFE, "pop_empty");

    // Address wraps modulo 2^24.
    start_read(24'hFFFFFF, 8'h02, 8'h02);
    wait_idle(200, "wrap_done");
    check("wrap_addr", {8'd0, flash_addr}, 32'h000001);
    pop_check("pop_wrap0");
    pop_check("pop_wrap1");

    // Length 0xC8 clamps; READ while busy is refused; ABORT ends it.
    start_read(24'h000010, 8'hC8, 8'h10);
    xfer(8'h01, 8'hEB, "read_busy");
    xfer(8'hCC, 8'hCC, "still_idle");
    xfer(8'h05, 8'hAA, "abort1");
    exp_q.delete();
    exp_addr_q.delete();
    wait_idle(100, "abort1_idle");
    xfer(8'h03, 8'h00, "status_after_abort1");

    // Length 0 clamps; full FIFO stalls requests until a POP; ABORT with a read outstanding.
    start_read(24'h000000, 8'h00, 8'h10);
    repeat (60) @(negedge clk);
    check("full_stall_rd", {31'd0, flash_do_read}, 32'd0);
    xfer(8'h03, 8'h84, "status_full_busy");
    model_en = 1'b0;
    pop_check("pop_resume");
    wait_rd(1'b1, 20, "resume_rd");
    check("resume_addr", {8'd0, flash_addr}, 32'h000004);
    xfer(8'h05, 8'hAA, "abort2");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (5) @(negedge clk);
    check("abort_rd_held", {31'd0, flash_do_read}, 32'd1);
    check("abort_busy_held", {31'd0, busy}, 32'd1);
    xfer(8'h03, 8'h80, "status_draining");
    model_en = 1'b1;
    wait_rd(1'b0, 20, "drain_rd_drop");
    check("drain_busy_drop", {31'd0, busy}, 32'd0);
    xfer(8'h03, 8'h00, "status_drained");
    xfer(8'h04, 8'hFE, "pop_drained");

    // Reset in the middle of an outstanding read; a late data pulse must be ignored.
    xfer(8'h02, 8'hAB, "led_off");
    model_en = 1'b0;
    start_read(24'h000020, 8'h02, 8'h02);
    wait_rd(1'b1, 20, "rst_test_rd");
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_send", {24'd0, send_data}, 32'h00);
    check("mid_rst_addr", {8'd0, flash_addr}, 32'h0);
    check("mid_rst_rd", {31'd0, flash_do_read}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_led", {31'd0, led}, 32'd1);
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    pulse_req = 1'b1;
    repeat (3) @(negedge clk);
    xfer(8'h03, 8'h00, "status_late_pulse");
    xfer(8'h04, 8'hFE, "pop_late_pulse");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
